dht11_scheduler: RTL and testbench
==================================

Name: dht11_scheduler

Overview:
- Sequences access to up to N DHT11 driver instances on behalf of the UART command decoder.
- Accepts one read request at a time and starts the addressed driver.
- Enforces the DHT11 minimum interval between reads of the same sensor, and serves the cached frame while a sensor is cooling down.
- Sits between the receiver/decoder path and the per-sensor DHT11 drivers; returns the 40-bit frame plus a status code.

Parameters:
N_SENSORS, 4, number of DHT11 drivers served; addresses 0..N_SENSORS-1 valid.
MIN_GAP_CYCLES, 230400, clock cycles between read starts on one sensor (2 s at 115200 Hz).
TIMEOUT_CYCLES, 115200, max cycles from driver start to busy falling.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  read request present
req_ready  output  1  scheduler can accept a request (high only in IDLE)
req_addr  input  8  sensor address
resp_valid  output  1  one-cycle pulse: resp_data/resp_status valid
resp_data  output  40  frame: [39:32] hum int, [31:24] hum dec, [23:16] temp int, [15:8] temp dec, [7:0] checksum
resp_status  output  2  0 fresh OK, 1 cached, 2 error (timeout/checksum), 3 bad address
dht_start  output  N_SENSORS  per-driver start level
dht_busy  input  N_SENSORS  per-driver busy (high while transaction runs)
dht_data  input  40*N_SENSORS  driver frames; sensor i at [40*i+39:40*i]

Behaviour:
- Reset values: req_ready 0 during reset (1 after, in IDLE), resp_valid 0, resp_data 0, resp_status 0, dht_start 0, all cache-valid flags 0, all cooldown counters 0, state IDLE. Reset mid-transaction drops dht_start immediately; no response is issued.
- Handshake: request accepted on a cycle with req_valid & req_ready; addr latched. Exactly one resp_valid pulse per accepted request. resp_data/resp_status hold their values until the next response.
- States:
  - IDLE: req_ready=1. On accept go to CHECK.
  - CHECK:
    - addr >= N_SENSORS: respond status 3, data 0; go to IDLE.
    - Cooldown[addr] != 0 and cache valid: respond status 1 with cached frame; go to IDLE. Total latency: response 2 cycles after accept.
    - Cooldown[addr] != 0 and cache invalid: go to HOLD.
    - Otherwise: go to START.
  - HOLD: wait until cooldown[addr] == 0, then go to START.
  - START:
    - Drive dht_start[addr]=1.
    - Load cooldown[addr]=MIN_GAP_CYCLES; clear timeout counter.
    - Stay until dht_busy[addr]=1, then go to WAIT.
  - WAIT:
    - dht_start[addr] stays 1 while busy.
    - On busy falling: deassert start, capture dht_data slice, respond status 0, update cache, set cache-valid; go to IDLE.
- Timeout:
  - The counter increments every cycle in START and WAIT.
  - Reaching TIMEOUT_CYCLES: deassert dht_start, respond status 2 with data 0, cache unchanged, cooldown kept; go to IDLE.
- Cooldown counters:
  - One per sensor; each decrements every cycle while nonzero and saturates at 0.
  - All counters run in every state.
  - CHECK and HOLD evaluate the registered counter value; a counter reaching 0 in the same cycle is seen as 0 the next cycle.
- Only one dht_start bit is ever high. Busy bits of non-addressed sensors are ignored.
- Address compare uses all 8 bits; no truncation or wrap.

Optional Feature:
- Macro: DHT11_CHECKSUM_EN.
- Defined: at capture, (b39:32 + b31:24 + b23:16 + b15:8) mod 256 is compared with b7:0.
  - Mismatch: status 2, frame still returned on resp_data, cache not updated, cooldown kept.
  - Match: status 0.
- Undefined: no check; every completed read returns status 0 and updates the cache.

Test Plan:
All scenarios use N_SENSORS=4, MIN_GAP_CYCLES=100, TIMEOUT_CYCLES=50.
1. Fresh read: req addr 2 after reset; driver 2 raises busy 3 cycles after start, holds it 20 cycles, frame 0x3700190027 (checksum 0x37+0x00+0x19+0x00=0x50 -> use 0x3700190050) -> dht_start[2] high until busy falls, resp status 0, data 0x3700190050; other start bits stay 0.
2. Cached: second req addr 2 issued 30 cycles after scenario 1 completes -> resp 2 cycles after accept, status 1, same data, dht_start stays 0.
3. Cooldown with empty cache: reset, read addr 1 times out (busy never rises), immediate re-request addr 1 -> response status 2 for the first request at 50 cycles; second request held in HOLD until cooldown expires (100 cycles after first start), then restart.
4. Bad address: req addr 0x07 -> status 3, data 0, latency 2 cycles, no start asserted.
5. Reset mid-WAIT: assert reset while busy is high -> dht_start drops same cycle, no resp_valid; next read of same sensor starts without HOLD (cooldown cleared).
6. DHT11_CHECKSUM_EN: frame 0x3700190051 -> status 2, data returned, subsequent cached request shows previous cache (or, with cache invalid, HOLD then reread).

Source files
------------

// File: rtl/dht11_scheduler.sv
// dht11_scheduler
// Serialises read requests from the command decoder across N_SENSORS DHT11
// drivers. It enforces a minimum gap between read starts on each sensor and
// serves the cached frame while that sensor is cooling down.
// Optional build macro: DHT11_CHECKSUM_EN. When it is defined, the frame
// checksum is validated at capture, and a bad frame is not cached.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | req_ready high, waiting for a request
// CHECK  | classify latched address: bad / cached / hold / start
// HOLD   | sensor cooling and no cached frame; wait for its cooldown to end
// START  | dht_start asserted, waiting for the driver to raise busy
// WAIT   | driver busy; capture its frame when busy falls
module dht11_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int MIN_GAP_CYCLES = 230400,
  parameter int TIMEOUT_CYCLES = 115200
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [7:0]                req_addr,
  output logic                      resp_valid,
  output logic [39:0]               resp_data,
  output logic [1:0]                resp_status,
  output logic [N_SENSORS-1:0]      dht_start,
  input  logic [N_SENSORS-1:0]      dht_busy,
  input  logic [40*N_SENSORS-1:0]   dht_data
);

  localparam int IDXW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int CDW  = $clog2(MIN_GAP_CYCLES + 1);
  localparam int TOW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CDW-1:0] GAP_LOAD = CDW'(MIN_GAP_CYCLES);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_FRESH  = 2'd0;
  localparam logic [1:0] ST_CACHED = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd2;
  localparam logic [1:0] ST_BADADR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_HOLD,
    S_START,
    S_WAIT
  } state_t;

  state_t               state;
  logic [7:0]           addr_q;
  logic [IDXW-1:0]      sel;
  logic [CDW-1:0]       cooldown [N_SENSORS];
  logic [39:0]          cache_data [N_SENSORS];
  logic [N_SENSORS-1:0] cache_valid;
  logic [TOW-1:0]       tout;
  logic                 addr_ok;
  logic                 busy_sel;
  logic                 frame_ok;
  logic [39:0]          frame_sel;

  // The full 8-bit address is compared so out-of-range addresses never alias.
  assign sel       = addr_q[IDXW-1:0];
  assign addr_ok   = ({24'd0, addr_q} < 32'(N_SENSORS));
  assign busy_sel  = dht_busy[sel];
  assign frame_sel = dht_data[40*int'(sel) +: 40];

`ifdef DHT11_CHECKSUM_EN
  logic [7:0] cs_sum;

  // Checksum is the byte-wise sum of the four data bytes, modulo 256.
  assign cs_sum   = frame_sel[39:32] + frame_sel[31:24] + frame_sel[23:16] + frame_sel[15:8];
  assign frame_ok = (cs_sum == frame_sel[7:0]);
`else
  assign frame_ok = 1'b1;
`endif

  // Scheduler FSM with registered outputs, per-sensor cooldowns and the frame cache.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_status <= ST_FRESH;
      dht_start   <= '0;
      addr_q      <= '0;
      tout        <= '0;
      cache_valid <= '0;
      for (int i = 0; i < N_SENSORS; i++) begin
        cooldown[i]   <= '0;
        cache_data[i] <= '0;
      end
    end else begin
      resp_valid <= 1'b0;

      // Every cooldown runs down in every state; a start reload below takes priority.
      for (int i = 0; i < N_SENSORS; i++) begin
        if (cooldown[i] != '0) begin
          cooldown[i] <= cooldown[i] - 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            state     <= S_CHECK;
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_CHECK: begin
          if (!addr_ok) begin
            resp_valid  <= 1'b1;
            resp_status <= ST_BADADR;
            resp_data   <= '0;
            req_ready   <= 1'b1;
            state       <= S_IDLE;
          end else if (cooldown[sel] != '0) begin
            if (cache_valid[sel]) begin
              resp_valid  <= 1'b1;
              resp_status <= ST_CACHED;
              resp_data   <= cache_data[sel];
              req_ready   <= 1'b1;
              state       <= S_IDLE;
            end else begin
              state <= S_HOLD;
            end
          end else begin
            dht_start[sel] <= 1'b1;
            cooldown[sel]  <= GAP_LOAD;
            tout           <= '0;
            state          <= S_START;
          end
        end

        S_HOLD: begin
          if (cooldown[sel] == '0) begin
            dht_start[sel] <= 1'b1;
            cooldown[sel]  <= GAP_LOAD;
            tout           <= '0;
            state          <= S_START;
          end
        end

        S_START: begin
          if (tout == TO_LAST) begin
            dht_start   <= '0;
            resp_valid  <= 1'b1;
            resp_status <= ST_ERROR;
            resp_data   <= '0;
            req_ready   <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tout <= tout + 1'b1;
            if (busy_sel) begin
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          // A completed frame wins over a timeout landing on the same cycle.
          if (!busy_sel) begin
            dht_start  <= '0;
            resp_valid <= 1'b1;
            resp_data  <= frame_sel;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
            if (frame_ok) begin
              resp_status      <= ST_FRESH;
              cache_data[sel]  <= frame_sel;
              cache_valid[sel] <= 1'b1;
            end else begin
              resp_status <= ST_ERROR;
            end
          end else if (tout == TO_LAST) begin
            dht_start   <= '0;
            resp_valid  <= 1'b1;
            resp_status <= ST_ERROR;
            resp_data   <= '0;
            req_ready   <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tout <= tout + 1'b1;
          end
        end

        default: begin
          dht_start <= '0;
          req_ready <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_scheduler.sv
// tb_dht11_scheduler
// Directed and randomized reads of dht11_scheduler, with N_SENSORS=4,
// MIN_GAP_CYCLES=100 and TIMEOUT_CYCLES=50. A behavioural driver model
// answers dht_start. An arithmetic reference model predicts each response:
// its cycle, status and data, plus the cycles on which dht_start rises and falls.
// Build with DHT11_CHECKSUM_EN defined to exercise the checksum variant.
module tb_dht11_scheduler;

  localparam int N   = 4;
  localparam int GAP = 100;
  localparam int TO  = 50;

  logic           clock;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [7:0]     req_addr;
  logic           resp_valid;
  logic [39:0]    resp_data;
  logic [1:0]     resp_status;
  logic [N-1:0]   dht_start;
  logic [N-1:0]   dht_busy;
  logic [40*N-1:0] dht_data;

  dht11_scheduler #(
    .N_SENSORS(N),
    .MIN_GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_status(resp_status),
    .dht_start(dht_start),
    .dht_busy(dht_busy),
    .dht_data(dht_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Sensor behaviour: busy rises d cycles after start is seen and lasts h cycles.
  int          d_cfg [N];
  int          h_cfg [N];
  logic [39:0] frame_cfg [N];

  // Reference model state.
  int          last_start [N];
  bit          cache_v [N];
  logic [39:0] cache_d [N];

  // Observations.
  int rise_cyc [N];
  int fall_cyc [N];
  int rise_cnt [N];
  int resp_cnt    = 0;
  int onehot_err  = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic bit sum_ok(input logic [39:0] f);
`ifdef DHT11_CHECKSUM_EN
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return s == f[7:0];
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [39:0] make_frame(input bit good);
    logic [39:0] f;
    f[39:8] = 32'($urandom);
    if (good) f[7:0] = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    else      f[7:0] = f[39:32] + f[31:24] + f[23:16] + f[15:8] + 8'd1;
    return f;
  endfunction

  function automatic int total_rises();
    int t = 0;
    for (int i = 0; i < N; i++) t += rise_cnt[i];
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      last_start[i] = -100000;
      cache_v[i]    = 1'b0;
    end
  endtask

  task automatic driver_proc();
    int s0 [N];
    bit act [N];
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    dht_busy = '0;
    dht_data = '0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        dht_data[40*i +: 40] = frame_cfg[i];
        if (!dht_start[i]) begin
          act[i]      = 1'b0;
          dht_busy[i] = 1'($urandom_range(0, 1));
        end else begin
          if (!act[i]) begin
            act[i] = 1'b1;
            s0[i]  = cyc;
          end
          dht_busy[i] = (cyc >= s0[i] + d_cfg[i]) && (cyc < s0[i] + d_cfg[i] + h_cfg[i]);
        end
      end
    end
  endtask

  task automatic monitor_proc();
    logic [N-1:0] prev = '0;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (dht_start[i] && !prev[i]) begin
          rise_cyc[i] = cyc;
          rise_cnt[i]++;
        end
        if (!dht_start[i] && prev[i]) fall_cyc[i] = cyc;
      end
      if ($countones(dht_start) > 1) onehot_err++;
      if (resp_valid) resp_cnt++;
      prev = dht_start;
    end
  endtask

  task automatic send_req(input logic [7:0] a, output int acc);
    int n = 0;
    while (!req_ready && n < 500) begin
      step();
      n++;
    end
    if (!req_ready) check("req_ready_wait", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_addr  = a;
    acc       = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input string tag);
    int acc, n, rc, exp_rc, exp_s, rises0, resp0, idx;
    logic [39:0] dexp;
    logic [1:0]  sexp;
    rises0 = total_rises();
    resp0  = resp_cnt;
    idx    = int'(a);
    send_req(a, acc);
    exp_s = -1;
    if (idx >= N) begin
      sexp = 2'd3; dexp = '0; exp_rc = acc + 2;
    end else if ((acc + 1 < last_start[idx] + GAP) && cache_v[idx]) begin
      sexp = 2'd1; dexp = cache_d[idx]; exp_rc = acc + 2;
    end else begin
      exp_s = (acc + 1 < last_start[idx] + GAP) ? last_start[idx] + GAP + 1 : acc + 2;
      last_start[idx] = exp_s;
      if (d_cfg[idx] + h_cfg[idx] <= TO - 1) begin
        exp_rc = exp_s + d_cfg[idx] + h_cfg[idx] + 1;
        dexp   = frame_cfg[idx];
        if (sum_ok(frame_cfg[idx])) begin
          sexp = 2'd0;
          cache_v[idx] = 1'b1;
          cache_d[idx] = frame_cfg[idx];
        end else begin
          sexp = 2'd2;
        end
      end else begin
        exp_rc = exp_s + TO; sexp = 2'd2; dexp = '0;
      end
    end
    n = 0;
    while (!resp_valid && n < 400) begin
      step();
      n++;
    end
    rc = resp_valid ? cyc : -1;
    check({tag, "_resp_cycle"}, 64'(rc), 64'(exp_rc));
    check({tag, "_status"}, {62'd0, resp_status}, {62'd0, sexp});
    check({tag, "_data"}, {24'd0, resp_data}, {24'd0, dexp});
    step();
    check({tag, "_pulse_low"}, {63'd0, resp_valid}, 64'd0);
    check({tag, "_data_hold"}, {24'd0, resp_data}, {24'd0, dexp});
    check({tag, "_resp_count"}, 64'(resp_cnt - resp0), 64'd1);
    check({tag, "_start_count"}, 64'(total_rises() - rises0), (exp_s >= 0) ? 64'd1 : 64'd0);
    if (exp_s >= 0) begin
      check({tag, "_start_rise"}, 64'(rise_cyc[idx]), 64'(exp_s));
      check({tag, "_start_fall"}, 64'(fall_cyc[idx]), 64'(exp_rc));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, s_rst, r, a_i, gap;
    for (int i = 0; i < N; i++) begin
      d_cfg[i] = 2; h_cfg[i] = 5; frame_cfg[i] = make_frame(1'b1);
      rise_cyc[i] = -1; fall_cyc[i] = -1; rise_cnt[i] = 0;
    end
    model_reset();
    reset = 1'b1; req_valid = 1'b0; req_addr = '0;
    fork
      driver_proc();
      monitor_proc();
    join_none

    repeat (3) step();
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_data", {24'd0, resp_data}, 64'd0);
    check("rst_resp_status", {62'd0, resp_status}, 64'd0);
    check("rst_dht_start", {60'd0, dht_start}, 64'd0);
    reset = 1'b0;
    step();
    check("idle_req_ready", {63'd0, req_ready}, 64'd1);

    // Fresh read, then a cached read 30 cycles later.
    d_cfg[2] = 3; h_cfg[2] = 20; frame_cfg[2] = 40'h3700190050;
    do_read(8'd2, "fresh2");
    repeat (30) step();
    do_read(8'd2, "cached2");

    // Out-of-range addresses, including one that would alias if truncated.
    do_read(8'h07, "bad07");
    do_read(8'h04, "bad04");
    do_read(8'h84, "bad84");
    do_read(8'hFF, "badFF");

    // Timeout with empty cache, then an immediate re-request held until cooldown ends.
    d_cfg[1] = 999; h_cfg[1] = 1;
    do_read(8'd1, "tmo1");
    d_cfg[1] = 5; h_cfg[1] = 10; frame_cfg[1] = make_frame(1'b1);
    do_read(8'd1, "hold1");

    // Reset while sensor 0 is busy.
    d_cfg[0] = 2; h_cfg[0] = 40; frame_cfg[0] = make_frame(1'b1);
    r = resp_cnt;
    send_req(8'd0, acc);
    s_rst = acc + 2;
    while (cyc < s_rst + 10) step();
    check("rst_mid_start_before", {63'd0, dht_start[0]}, 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_start_drop", {60'd0, dht_start}, 64'd0);
    check("rst_mid_no_resp", {63'd0, resp_valid}, 64'd0);
    repeat (3) step();
    reset = 1'b0;
    model_reset();
    step();
    check("rst_mid_resp_count", 64'(resp_cnt - r), 64'd0);
    do_read(8'd0, "after_rst0");
    do_read(8'd2, "after_rst2");

    // Checksum handling: good frame cached, then a frame with a bad checksum.
    d_cfg[3] = 4; h_cfg[3] = 8; frame_cfg[3] = 40'h3700190050;
    do_read(8'd3, "cs_good3");
    repeat (110) step();
    frame_cfg[3] = 40'h3700190051;
    do_read(8'd3, "cs_bad3");
    do_read(8'd3, "cs_cached3");

    // Randomized reads against the reference model.
    for (int k = 0; k < 30; k++) begin
      a_i = $urandom_range(0, 5);
      if ($urandom_range(0, 9) == 0) a_i = $urandom_range(6, 255);
      if (a_i < N) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          d_cfg[a_i] = 999; h_cfg[a_i] = 1;
        end else if (r == 1) begin
          d_cfg[a_i] = $urandom_range(1, 20); h_cfg[a_i] = TO - 1 - d_cfg[a_i];
        end else if (r == 2) begin
          d_cfg[a_i] = $urandom_range(1, 20); h_cfg[a_i] = TO - d_cfg[a_i];
        end else begin
          d_cfg[a_i] = $urandom_range(1, 8); h_cfg[a_i] = $urandom_range(1, 25);
        end
        frame_cfg[a_i] = make_frame($urandom_range(0, 3) != 0);
      end
      gap = $urandom_range(0, 120);
      repeat (gap) step();
      do_read(8'(a_i), "rnd");
    end

    check("start_onehot", 64'(onehot_err), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
